// File: rtl/jtopl_pkg.sv
// Shared constants and stage types for the OPL operator output path.
package jtopl_pkg;
  localparam int OPL_CH    = 9;
  localparam int OPL_SLOTS = 2 * OPL_CH;
  localparam int PHASE_W   = 10;
  localparam int ATT_W     = 13;
  localparam int OUT_W     = 13;
  localparam real OPL_PI   = 3.14159265358979323846;

  typedef enum logic [1:0] {
    WAV_SINE  = 2'd0,
    WAV_HALF  = 2'd1,
    WAV_ABS   = 2'd2,
    WAV_QUART = 2'd3
  } wav_e;

  typedef struct packed {
    logic [7:0] idx;
    logic       neg;
    logic       zero;
  } dec_t;

  typedef struct packed {
    logic [ATT_W-1:0] atten;
    logic             neg;
  } att_t;

  // Attenuation past 13 bits is simply silence.
  function automatic logic [ATT_W-1:0] sat_att(input logic [ATT_W:0] sum);
    return sum[ATT_W] ? '1 : sum[ATT_W-1:0];
  endfunction
endpackage

// File: rtl/jtopl_op_tables.sv
// Quarter-wave log-sine ROM and fractional exponent ROM, built at elaboration.
module jtopl_op_tables import jtopl_pkg::*; (
  input  logic [7:0]  logsin_addr,
  input  logic [7:0]  exp_addr,
  output logic [11:0] logsin,
  output logic [9:0]  expv
);
  logic [11:0] ls_rom [256];
  logic [9:0]  ex_rom [256];

  for (genvar i = 0; i < 256; i++) begin : g_rom
    localparam int LS = $rtoi(-$ln($sin((i + 0.5) * OPL_PI / 512.0)) / $ln(2.0) * 256.0 + 0.5);
    localparam int EX = $rtoi($pow(2.0, i / 256.0) * 1024.0 + 0.5) - 1024;
    assign ls_rom[i] = LS[11:0];
    assign ex_rom[i] = EX[9:0];
  end

  assign logsin = ls_rom[logsin_addr];
  assign expv   = ex_rom[exp_addr];
endmodule

// File: rtl/jtopl_sh_rst.sv
// Clock-enabled shift register with synchronous clear.
module jtopl_sh_rst #(
  parameter int W = 13,
  parameter int N = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cen,
  input  logic [W-1:0] din,
  output logic [W-1:0] drop
);
  logic [N-1:0][W-1:0] bits;

  always_ff @(posedge clk) begin
    if (rst)      bits <= '0;
    else if (cen) bits <= {bits[N-2:0], din};
  end

  assign drop = bits[N-1];
endmodule

// File: rtl/jtopl_op_calc.sv
// Operator output stage: FM/feedback, waveform decode, log-sin + exp lookup.
module jtopl_op_calc import jtopl_pkg::*; #(
  parameter int CH = OPL_CH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cenop,
  input  logic [PHASE_W-1:0] phase_IV,
  input  logic               op_IV,
  input  logic               con_IV,
  input  logic [2:0]         fb_IV,
  input  logic [1:0]         wavsel_IV,
  input  logic               wave_en,
  input  logic [9:0]         eg_V,
  output logic [OUT_W-1:0]   op_result
);
  localparam int STAGES = 1;

  logic [OUT_W-1:0]   p1, p2;
  logic signed [13:0] fb_sum, fb_sh;
  logic [PHASE_W-1:0] mod, pm;
  wav_e               w;
  dec_t               dec_n, s_v;
  att_t               att_n, s_vi;
  logic [11:0]        ls, mag_base, mag;
  logic [9:0]         e;
  logic [7:0]         exp_addr;
  logic [OUT_W-1:0]   res_n;
  logic [STAGES:0]    vld_pipe;

  // p1 lines up with the same modulator one slot period back, p2 two back.
  jtopl_sh_rst #(.W(OUT_W), .N(2*CH-3)) u_d1 (
    .clk(clk), .rst(rst), .cen(cenop), .din(op_result), .drop(p1)
  );
  jtopl_sh_rst #(.W(OUT_W), .N(2*CH)) u_d2 (
    .clk(clk), .rst(rst), .cen(cenop), .din(p1), .drop(p2)
  );

  always_comb begin
    fb_sum = {p1[OUT_W-1], p1} + {p2[OUT_W-1], p2};
    fb_sh  = fb_sum >>> (4'd10 - {1'b0, fb_IV});
    mod    = '0;
    if (op_IV) begin
      if (fb_IV != 3'd0) mod = fb_sh[PHASE_W-1:0];
    end else if (!con_IV) begin
      mod = op_result[PHASE_W:1];
    end
    pm = phase_IV + mod;
  end

  always_comb begin
    w          = wave_en ? wav_e'(wavsel_IV) : WAV_SINE;
    dec_n.idx  = pm[8] ? ~pm[7:0] : pm[7:0];
    dec_n.neg  = pm[9];
    dec_n.zero = 1'b0;
    case (w)
      WAV_HALF:  dec_n.zero = pm[9];
      WAV_ABS:   dec_n.neg  = 1'b0;
      WAV_QUART: begin
        dec_n.zero = pm[8];
        dec_n.neg  = 1'b0;
      end
      default: ;
    endcase
  end

  assign exp_addr = ~s_vi.atten[7:0];

  jtopl_op_tables u_tab (
    .logsin_addr(s_v.idx), .exp_addr(exp_addr), .logsin(ls), .expv(e)
  );

  always_comb begin
    att_n.atten = s_v.zero ? '1 : sat_att({2'b0, ls} + {1'b0, eg_V, 3'b0});
    att_n.neg   = s_v.neg;
  end

  // Implicit leading one, then the integer part of the attenuation shifts down.
  always_comb begin
    mag_base = {1'b1, e, 1'b0};
    mag      = mag_base >> s_vi.atten[12:8];
    res_n    = s_vi.neg ? -{1'b0, mag} : {1'b0, mag};
  end

  // vld_pipe keeps cleared stage registers from leaking a post-reset sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_v       <= '0;
      s_vi      <= '0;
      vld_pipe  <= '0;
      op_result <= '0;
    end else if (cenop) begin
      s_v       <= dec_n;
      s_vi      <= att_n;
      vld_pipe  <= {vld_pipe[STAGES-1:0], 1'b1};
      op_result <= vld_pipe[STAGES] ? res_n : '0;
    end
  end
endmodule

// File: tb/tb_jtopl_op_calc.sv
// Bench for jtopl_op_calc: fixed vectors, FM/feedback sequences, random slots.
module tb_jtopl_op_calc;
  localparam int CH = 9;
  localparam int SL = 2 * CH;
  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst, cenop, op_IV, con_IV, wave_en;
  logic [9:0]  phase_IV, eg_V;
  logic [2:0]  fb_IV;
  logic [1:0]  wavsel_IV;
  logic [12:0] op_result;

  always #5 clk = ~clk;

  jtopl_op_calc #(.CH(CH)) dut (
    .clk(clk), .rst(rst), .cenop(cenop), .phase_IV(phase_IV), .op_IV(op_IV),
    .con_IV(con_IV), .fb_IV(fb_IV), .wavsel_IV(wavsel_IV), .wave_en(wave_en),
    .eg_V(eg_V), .op_result(op_result)
  );

  typedef struct {
    logic [9:0] ph;
    logic       op;
    logic       con;
    logic [2:0] fb;
    logic [1:0] ws;
    logic       we;
    logic [9:0] eg;   // presented with this tick, belongs to the previous slot
  } slot_t;

  typedef struct {
    logic [9:0] ph;
    logic [1:0] ws;
    logic       we;
    logic [9:0] eg;
    int         expv;
    string      name;
  } vec_t;

  int    checks = 0, errors = 0;
  int    ls_t[256], ex_t[256];
  slot_t sv[512];
  int    res[512];
  int    k;
  vec_t  vt[9];

  task automatic check(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tick %0d)", name, got, expv, k);
    end
  endtask

  function automatic int res_at(input int m);
    return (m < 0) ? 0 : res[m];
  endfunction

  // Sample value of one slot from its inputs and the history it depends on.
  function automatic int model(input slot_t s, input logic [9:0] eg,
                               input int cur, input int p1, input int p2);
    int mod, pm, idx, att, wv, mag;
    bit neg, sil;
    mod = 0;
    if (s.op) begin
      if (s.fb != 0) mod = ((p1 + p2) >>> (10 - int'(s.fb))) & 1023;
    end else if (!s.con) begin
      mod = (cur >>> 1) & 1023;
    end
    pm  = (int'(s.ph) + mod) % 1024;
    idx = pm % 256;
    if ((pm / 256) % 2 == 1) idx = 255 - idx;
    neg = (pm >= 512);
    sil = 0;
    wv  = s.we ? int'(s.ws) : 0;
    if (wv == 1 && neg) sil = 1;
    if (wv == 3 && (pm / 256) % 2 == 1) sil = 1;
    if (wv >= 2) neg = 0;
    att = sil ? 8191 : ls_t[idx] + int'(eg) * 8;
    if (att > 8191) att = 8191;
    mag = ((ex_t[255 - att % 256] + 1024) * 2) >> (att / 256);
    return neg ? -mag : mag;
  endfunction

  task automatic drive(input slot_t s);
    phase_IV  = s.ph;
    op_IV     = s.op;
    con_IV    = s.con;
    fb_IV     = s.fb;
    wavsel_IV = s.ws;
    wave_en   = s.we;
    eg_V      = s.eg;
  endtask

  task automatic run_tick(input string name);
    check(name, $signed(op_result), res_at(k - 3));
    drive(sv[k]);
    cenop = 1'b1;
    @(posedge clk); #1;
    cenop = 1'b0;
    if (k >= 1)
      res[k-1] = model(sv[k-1], sv[k].eg, res_at(k - 4), res_at(k - 1 - SL), res_at(k - 1 - 2*SL));
    k++;
  endtask

  task automatic raw_tick();
    cenop = 1'b1;
    @(posedge clk); #1;
    cenop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      phase_IV = 10'($urandom);
      eg_V     = 10'($urandom);
      fb_IV    = 3'($urandom);
      op_IV    = 1'($urandom);
      con_IV   = 1'($urandom);
      cenop    = 1'b0;
      @(posedge clk); #1;
      check("hold", $signed(op_result), res_at(k - 3));
    end
  endtask

  task automatic do_reset(input int n, input bit ce);
    rst   = 1'b1;
    cenop = ce;
    repeat (n) begin
      @(posedge clk); #1;
      check("rst_clr", $signed(op_result), 0);
    end
    rst   = 1'b0;
    cenop = 1'b0;
    k     = 0;
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      sv[i].ph  = 10'($urandom);
      sv[i].op  = 1'($urandom);
      sv[i].con = 1'($urandom);
      sv[i].fb  = 3'($urandom);
      sv[i].ws  = 2'($urandom);
      sv[i].we  = 1'($urandom);
      sv[i].eg  = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 63));
    end
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      run_tick("rand");
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ls_t[i] = $rtoi(-$ln($sin((i + 0.5) * PI / 512.0)) / $ln(2.0) * 256.0 + 0.5);
      ex_t[i] = $rtoi($pow(2.0, i / 256.0) * 1024.0 + 0.5) - 1024;
    end
    rst = 1'b0;
    cenop = 1'b0;
    k = 0;

    // Reset with a full-scale carrier waiting at the input.
    for (int i = 0; i < 16; i++) sv[i] = '{10'h0FF, 1'b0, 1'b1, 3'd0, 2'd0, 1'b0, 10'd0};
    drive(sv[0]);
    do_reset(5, 1'b1);
    for (int i = 0; i < 3; i++) run_tick("rst_lat");
    check("rst_peak", $signed(op_result), 4084);
    run_tick("rst_lat");

    // Fixed vectors: carrier, additive, no feedback.
    vt[0] = '{10'h0FF, 2'd0, 1'b0, 10'h000,  4084, "peak_pos"};
    vt[1] = '{10'h2FF, 2'd0, 1'b0, 10'h000, -4084, "peak_neg"};
    vt[2] = '{10'h000, 2'd0, 1'b0, 10'h000,    12, "phase_zero"};
    vt[3] = '{10'h0FF, 2'd0, 1'b0, 10'h020,  2042, "eg_half"};
    vt[4] = '{10'h0FF, 2'd0, 1'b0, 10'h3FF,     0, "eg_sat"};
    vt[5] = '{10'h2FF, 2'd1, 1'b1, 10'h000,     0, "wav_half"};
    vt[6] = '{10'h2FF, 2'd2, 1'b1, 10'h000,  4084, "wav_abs"};
    vt[7] = '{10'h1FF, 2'd3, 1'b1, 10'h000,     0, "wav_quart"};
    vt[8] = '{10'h2FF, 2'd1, 1'b0, 10'h000, -4084, "wav_dis"};
    op_IV = 1'b0;
    con_IV = 1'b1;
    fb_IV = 3'd0;
    for (int i = 0; i < 9; i++) begin
      phase_IV  = vt[i].ph;
      wavsel_IV = vt[i].ws;
      wave_en   = vt[i].we;
      eg_V      = vt[i].eg;
      repeat (3) raw_tick();
      check(vt[i].name, $signed(op_result), vt[i].expv);
    end

    // FM: modulator output steers the carrier three slots later.
    drive(sv[0]);
    do_reset(2, 1'b1);
    for (int i = 0; i < 10; i++) sv[i] = '{10'h0FF, 1'b0, 1'b1, 3'd0, 2'd0, 1'b0, 10'd0};
    sv[0] = '{10'h0FF, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 10'd0};
    sv[3] = '{10'h000, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 10'd0};
    for (int i = 0; i < 10; i++) begin
      if (i == 3) check("fm_mod", $signed(op_result), 4084);
      if (i == 6) check("fm_car", $signed(op_result), -137);
      run_tick("fm");
    end

    // Self-feedback on slot 0 across four slot periods.
    do_reset(2, 1'b1);
    for (int i = 0; i < 4*SL + 4; i++)
      sv[i] = (i % SL == 0) ? '{10'h0FF, 1'b1, 1'b0, 3'd7, 2'd0, 1'b0, 10'd0}
                            : '{10'h0FF, 1'b0, 1'b1, 3'd0, 2'd0, 1'b0, 10'd0};
    for (int i = 0; i < 4*SL + 4; i++) begin
      if (i == 3)      check("fb_first", $signed(op_result), 4084);
      if (i == SL + 3) check("fb_second", $signed(op_result), -4084);
      run_tick("fb");
    end

    // Random slots, then a reset landing mid-pipeline with cenop low.
    fill_random(300);
    do_reset(3, 1'b1);
    run_random(300);
    fill_random(300);
    do_reset(1, 1'b0);
    run_random(300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
